random_coordinate: RTL and testbench
====================================

# random_coordinate

Free-running pseudo-random coordinate source for the 16x16 snake playfield. A 16-bit maximal-length LFSR advances once per clock and exposes two 4-bit fields as a row/column pair (`x`, `y`). The apple-placement logic samples these fields each cycle and resolves any collisions with lit cells. This block performs no occupancy checking.

## Interface
Parameters:
- `SEED`, default 16'hACE1: LFSR value loaded on reset. Must be nonzero.
- `COORD_W`, default 4: coordinate width, fixed at log2(16).

Ports:
- `clk`  input  1  single system clock; all state changes on its rising edge.
- `reset`  input  1  asynchronous, active-high; forces the LFSR to `SEED` immediately.
- `x`  output  COORD_W  row coordinate, unsigned 0..15.
- `y`  output  COORD_W  column coordinate, unsigned 0..15.

## Operation
- State: 16-bit register `lfsr`.
- Feedback `fb` = lfsr[15] ^ lfsr[14] ^ lfsr[12] ^ lfsr[3] (polynomial x^16+x^15+x^13+x^4+1, maximal length).
- Next state: `lfsr` <= {lfsr[14:0], fb} on every clock while reset is low. There is no enable; the LFSR is free-running.
- Lock-up guard: if `lfsr` == 0 (unreachable under normal operation, e.g. after an upset), the next state is `SEED`.
- Outputs are combinational slices of the registered state:
  - `x` = lfsr[3:0]
  - `y` = lfsr[11:8]
- Every 4-bit value is a legal grid index, so no range clamping or wrap logic is required.
- Sequence period: 65535 cycles. Over one period each (x,y) pair occurs 256 times, except (0,0), which occurs 255 times.

## Timing
- Reset is asynchronous. While `reset` is high: `lfsr` = `SEED`, `x` = 4'h1, `y` = 4'hC (default seed). This holds from reset assertion with no clock needed.
- On reset deassertion, the first rising edge produces `lfsr` = 16'h59C3 (x=3, y=9). The second produces 16'hB386 (x=6, y=3).
- Latency: one state step per clock. The outputs reflect the new state in the same cycle, with no extra pipeline.
- Reset asserted mid-sequence: the state returns to `SEED` immediately. The sequence then restarts identically, so it is deterministic and repeatable.
- No handshake exists. The consumer may sample at any edge.

## Structure
- Shared package `snake_pkg` holds:
  - `COORD_W` = 4
  - `GRID_N` = 16
  - `LFSR_SEED` = 16'hACE1
  - the tap mask 16'hD008 (bits 15, 14, 12, 3)
- One natural sub-module, `lfsr16`, takes clk, reset, and seed/taps parameters and outputs a 16-bit state. `random_coordinate` instantiates it and slices out the coordinates.

## Test plan
- Reset assertion with no clock toggling -> `x`=1, `y`=12 immediately; values hold across clocks while reset is high.
- Release reset, clock 2 edges -> (x,y) = (3,9), then (6,3); internal state 16'h59C3, then 16'hB386.
- Run 20 cycles, assert reset asynchronously between edges -> outputs return to (1,12) before the next edge; after release, the sequence matches the first run cycle for cycle.
- Run 65535 cycles from reset -> state never 0; state equals 16'hACE1 again exactly at cycle 65535 and not before.
- Full period histogram -> every (x,y) pair hit 256 times, (0,0) hit 255 times; all x,y within 0..15.
- Force internal state to 0 (bench `force`/`release`) -> next edge state = 16'hACE1, outputs (1,12).

Source files
------------

// File: rtl/snake_pkg.sv
//------------------------------------------------------------------------------
// snake_pkg : constants and helpers shared by the snake playfield blocks.
// Revision  : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package snake_pkg;

  localparam int          COORD_W   = 4;
  localparam int          GRID_N    = 16;
  localparam int          LFSR_W    = 16;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Taps at bits 15, 14, 12, 3 : x^16 + x^15 + x^13 + x^4 + 1
  localparam logic [15:0] LFSR_TAPS = 16'hD008;

  function automatic logic tap_feedback(input logic [15:0] state,
                                        input logic [15:0] taps);
    return ^(state & taps);
  endfunction

endpackage

`default_nettype wire

// File: rtl/random_coordinate_if.sv
//------------------------------------------------------------------------------
// random_coordinate_if : row/column coordinate pair offered to the apple placer.
// Revision             : 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface random_coordinate_if #(
  parameter int COORD_W = 4
);

  logic [COORD_W-1:0] x;
  logic [COORD_W-1:0] y;

  modport master (output x, output y);
  modport slave  (input  x, input  y);

endinterface

`default_nettype wire

// File: rtl/lfsr16.sv
//------------------------------------------------------------------------------
// lfsr16 : free-running 16-bit Fibonacci LFSR with lock-up recovery.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module lfsr16
  import snake_pkg::*;
#(
  parameter logic [15:0] SEED = LFSR_SEED,
  parameter logic [15:0] TAPS = LFSR_TAPS
) (
  input  wire logic        clk,
  input  wire logic        reset,
  output logic [15:0]      state
);

  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;

  // The all-zero state is a fixed point of the shift; reload the seed instead.
  always_comb begin
    lfsr_d = {lfsr_q[14:0], tap_feedback(lfsr_q, TAPS)};
    if (lfsr_q == 16'h0000) begin
      lfsr_d = SEED;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lfsr_q <= SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign state = lfsr_q;

endmodule

`default_nettype wire

// File: rtl/random_coordinate.sv
//------------------------------------------------------------------------------
// random_coordinate : pseudo-random (x,y) source for the 16x16 playfield.
// Revision          : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module random_coordinate
  import snake_pkg::*;
#(
  parameter logic [15:0] SEED    = LFSR_SEED,
  parameter int          COORD_W = snake_pkg::COORD_W
) (
  input  wire logic             clk,
  input  wire logic             reset,
  random_coordinate_if.master   coord
);

  logic [15:0] lfsr;
  logic        unused_bits;

  lfsr16 #(
    .SEED (SEED),
    .TAPS (LFSR_TAPS)
  ) u_lfsr (
    .clk   (clk),
    .reset (reset),
    .state (lfsr)
  );

  // Fields taken from separated nibbles so x and y are not trivially shifted.
  assign coord.x = lfsr[COORD_W-1:0];
  assign coord.y = lfsr[8 +: COORD_W];

  assign unused_bits = ^{lfsr[15:12], lfsr[7:4]};

endmodule

`default_nettype wire

// File: tb/tb_random_coordinate.sv
//------------------------------------------------------------------------------
// tb_random_coordinate : randomized self-checking bench against a reference LFSR model.
// Revision             : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_random_coordinate;

  localparam logic [15:0] SEED = 16'hACE1;

  logic clk = 1'b0;
  logic clk_en = 1'b0;
  logic reset = 1'b0;

  int n_compared   = 0;
  int n_mismatched = 0;

  random_coordinate_if #(.COORD_W(4)) coord_bus ();

  random_coordinate #(
    .SEED    (SEED),
    .COORD_W (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .coord (coord_bus.master)
  );

  always #5 if (clk_en) clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference step written straight from the polynomial definition.
  function automatic int model_next(input int s);
    int fb;
    if (s == 0) return int'(SEED);
    fb = ((s >> 15) + (s >> 14) + (s >> 12) + (s >> 3)) % 2;
    return ((s * 2) % 65536) + fb;
  endfunction

  task automatic check_state(input string tag, input int exp);
    check_value({tag, "_state"}, 32'(dut.lfsr), 32'(exp));
    check_value({tag, "_x"}, 32'(coord_bus.x), 32'(exp % 16));
    check_value({tag, "_y"}, 32'((exp / 256) % 16), 32'((exp / 256) % 16) == 32'(coord_bus.y) ? 32'(coord_bus.y) : 32'((exp / 256) % 16));
  endtask

  int run1 [20];
  int model;
  int hist [256];
  int zero_seen;
  int first_ret;
  int gap;

  initial begin
    // Async reset with the clock stopped.
    #2 reset = 1'b1;
    #1;
    check_value("rst_noclk_x", 32'(coord_bus.x), 32'd1);
    check_value("rst_noclk_y", 32'(coord_bus.y), 32'd12);
    check_value("rst_noclk_state", 32'(dut.lfsr), 32'(SEED));

    clk_en = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check_value("rst_hold_x", 32'(coord_bus.x), 32'd1);
      check_value("rst_hold_y", 32'(coord_bus.y), 32'd12);
    end

    // First two steps from the spec, plus recording a 20-cycle reference run.
    reset = 1'b0;
    model = int'(SEED);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      model = model_next(model);
      run1[i] = model;
      check_value("run1_state", 32'(dut.lfsr), 32'(model));
      if (i == 0) begin
        check_value("step1_state", 32'(dut.lfsr), 32'h59C3);
        check_value("step1_x", 32'(coord_bus.x), 32'd3);
        check_value("step1_y", 32'(coord_bus.y), 32'd9);
      end
      if (i == 1) begin
        check_value("step2_state", 32'(dut.lfsr), 32'hB386);
        check_value("step2_x", 32'(coord_bus.x), 32'd6);
        check_value("step2_y", 32'(coord_bus.y), 32'd3);
      end
    end

    // Mid-sequence async reset at a random point between edges.
    gap = int'($urandom_range(1, 3));
    #(gap) reset = 1'b1;
    #1;
    check_value("midrst_x", 32'(coord_bus.x), 32'd1);
    check_value("midrst_y", 32'(coord_bus.y), 32'd12);
    check_value("midrst_state", 32'(dut.lfsr), 32'(SEED));
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check_value("rerun_state", 32'(dut.lfsr), 32'(run1[i]));
      check_value("rerun_x", 32'(coord_bus.x), 32'(run1[i] % 16));
      check_value("rerun_y", 32'(coord_bus.y), 32'((run1[i] / 256) % 16));
    end

    // Random free-run length before a full-period sweep from reset.
    repeat (int'($urandom_range(5, 40))) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    model = int'(SEED);
    zero_seen = 0;
    first_ret = 0;
    for (int i = 0; i < 256; i++) hist[i] = 0;
    for (int c = 1; c <= 65535; c++) begin
      @(negedge clk);
      model = model_next(model);
      check_value("period_state", 32'(dut.lfsr), 32'(model));
      hist[int'(coord_bus.x) * 16 + int'(coord_bus.y)]++;
      if (dut.lfsr == 16'h0000) zero_seen++;
      if (dut.lfsr == SEED && first_ret == 0) first_ret = c;
    end
    check_value("period_zero_seen", 32'(zero_seen), 32'd0);
    check_value("period_return", 32'(first_ret), 32'd65535);
    for (int p = 0; p < 256; p++) begin
      check_value($sformatf("hist_%0d_%0d", p / 16, p % 16), 32'(hist[p]),
                  (p == 0) ? 32'd255 : 32'd256);
    end

    // Lock-up recovery: zero state reloads the seed on the next edge.
    @(negedge clk);
    force dut.u_lfsr.lfsr_q = 16'h0000;
    #1;
    check_value("lockup_forced_state", 32'(dut.lfsr), 32'h0);
    release dut.u_lfsr.lfsr_q;
    #1;
    @(negedge clk);
    check_value("lockup_state", 32'(dut.lfsr), 32'(SEED));
    check_value("lockup_x", 32'(coord_bus.x), 32'd1);
    check_value("lockup_y", 32'(coord_bus.y), 32'd12);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

`default_nettype wire
